// File: rtl/input_conditioner_if.sv
// Raw board inputs and conditioned outputs for the multiplier front end.
// master drives the raw side; slave is the conditioner.
interface input_conditioner_if #(
  parameter int S_WIDTH = 8
) ();
  logic               Run_n_raw;
  logic               ClearA_LoadB_n_raw;
  logic [S_WIDTH-1:0] S_raw;
  logic               Busy;
  logic               Run;
  logic               ClearA_LoadB;
  logic               Run_pulse;
  logic               ClearA_LoadB_pulse;
  logic [S_WIDTH-1:0] S;

  modport master (
    output Run_n_raw,
    output ClearA_LoadB_n_raw,
    output S_raw,
    output Busy,
    input  Run,
    input  ClearA_LoadB,
    input  Run_pulse,
    input  ClearA_LoadB_pulse,
    input  S
  );

  modport slave (
    input  Run_n_raw,
    input  ClearA_LoadB_n_raw,
    input  S_raw,
    input  Busy,
    output Run,
    output ClearA_LoadB,
    output Run_pulse,
    output ClearA_LoadB_pulse,
    output S
  );
endinterface

// File: rtl/input_conditioner.sv
// Key synchronizer/debouncer and Busy-gated operand register
// feeding the shift-add multiplier.
module input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int S_WIDTH         = 8
) (
  input logic                Clk,
  input logic                Reset,
  input_conditioner_if.slave io
);
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } key_st_e;

  logic [1:0] raw;
  logic [1:0] q1;
  logic [1:0] q2;
  logic [1:0] lvl;
  logic [1:0] pls;

  logic [S_WIDTH-1:0] s1;
  logic [S_WIDTH-1:0] s2;
  logic [S_WIDTH-1:0] s_q;

  assign raw = {io.ClearA_LoadB_n_raw, io.Run_n_raw};

  // Keys sync to 1 (released) so reset never looks like a press
  always_ff @(posedge Clk) begin
    if (Reset) begin
      q1 <= '1;
      q2 <= '1;
      s1 <= '0;
      s2 <= '0;
      s_q <= '0;
    end else begin
      q1 <= raw;
      q2 <= q1;
      s1 <= io.S_raw;
      s2 <= s1;
      if (!io.Busy) s_q <= s2;
    end
  end

  for (genvar k = 0; k < 2; k++) begin : g_key
    key_st_e        st;
    key_st_e        st_nx;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nx;
    logic           pls_q;
    logic           pls_nx;
    logic           p;

    assign p = ~q2[k];

    always_ff @(posedge Clk) begin
      if (Reset) begin
        st    <= RELEASED;
        cnt   <= '0;
        pls_q <= 1'b0;
      end else begin
        st    <= st_nx;
        cnt   <= cnt_nx;
        pls_q <= pls_nx;
      end
    end

    always_comb begin
      st_nx  = st;
      cnt_nx = cnt;
      pls_nx = 1'b0;
      unique case (st)
        RELEASED: begin
          if (p) begin
            st_nx  = PRESS_WAIT;
            cnt_nx = '0;
          end
        end
        PRESS_WAIT: begin
          if (!p) begin
            st_nx = RELEASED;
          end else if (cnt == CNT_LAST) begin
            st_nx  = PRESSED;
            pls_nx = 1'b1;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
        PRESSED: begin
          if (!p) begin
            st_nx  = RELEASE_WAIT;
            cnt_nx = '0;
          end
        end
        RELEASE_WAIT: begin
          if (p) begin
            st_nx = PRESSED;
          end else if (cnt == CNT_LAST) begin
            st_nx = RELEASED;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
        default: st_nx = RELEASED;
      endcase
    end

    assign lvl[k] = (st == PRESSED) || (st == RELEASE_WAIT);
    assign pls[k] = pls_q;
  end

  assign io.Run                = lvl[0];
  assign io.ClearA_LoadB       = lvl[1];
  assign io.Run_pulse          = pls[0];
  assign io.ClearA_LoadB_pulse = pls[1];
  assign io.S                  = s_q;
endmodule

// File: tb/tb_input_conditioner.sv
// Randomized and directed checks of input_conditioner against
// a run-length debounce model.
module tb_input_conditioner;
  localparam int DEB = 4;
  localparam int SW  = 8;

  logic Clk;
  logic Reset;
  int   ncmp;
  int   nfail;

  input_conditioner_if #(.S_WIDTH(SW)) io ();

  input_conditioner #(
    .DEBOUNCE_CYCLES(DEB),
    .S_WIDTH(SW)
  ) dut (
    .Clk(Clk),
    .Reset(Reset),
    .io(io.slave)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Model: a key's accepted level flips once the synced input has
  // disagreed with it for DEB+1 consecutive sampled edges.
  logic [1:0]    mq1;
  logic [1:0]    mq2;
  logic [SW-1:0] ms1;
  logic [SW-1:0] ms2;
  logic [SW-1:0] mS;
  logic [1:0]    mlvl;
  logic [1:0]    mpls;
  int            mrun [2];

  always @(posedge Clk) begin
    if (Reset) begin
      mq1 = '1;
      mq2 = '1;
      ms1 = '0;
      ms2 = '0;
      mS = '0;
      mlvl = '0;
      mpls = '0;
      mrun[0] = 0;
      mrun[1] = 0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        mpls[k] = 1'b0;
        if (~mq2[k] != mlvl[k]) begin
          mrun[k] = mrun[k] + 1;
          if (mrun[k] == DEB + 1) begin
            mlvl[k] = ~mq2[k];
            mrun[k] = 0;
            mpls[k] = ~mq2[k];
          end
        end else begin
          mrun[k] = 0;
        end
      end
      if (!io.Busy) mS = ms2;
      ms2 = ms1;
      ms1 = io.S_raw;
      mq2 = mq1;
      mq1 = {io.ClearA_LoadB_n_raw, io.Run_n_raw};
    end
  end

  function automatic logic [SW+3:0] dut_vec();
    return {io.Run, io.ClearA_LoadB, io.Run_pulse,
            io.ClearA_LoadB_pulse, io.S};
  endfunction

  function automatic logic [SW+3:0] mod_vec();
    return {mlvl[0], mlvl[1], mpls[0], mpls[1], mS};
  endfunction

  task automatic test_reset();
    Reset = 1'b1;
    io.Run_n_raw = 1'b1;
    io.ClearA_LoadB_n_raw = 1'b1;
    io.S_raw = 8'hA5;
    io.Busy = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    ncmp++;
    if (dut_vec() !== '0) begin
      nfail++;
      $display("FAIL reset_outs got=%h want=0", dut_vec());
    end
    Reset = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    ncmp++;
    if (io.S !== 8'h00) begin
      nfail++;
      $display("FAIL reset_s_edge2 got=%h want=00", io.S);
    end
    @(negedge Clk);
    ncmp++;
    if (io.S !== 8'hA5) begin
      nfail++;
      $display("FAIL reset_s_edge3 got=%h want=a5", io.S);
    end
  endtask

  task automatic test_press_latency();
    logic [1:0] want;
    io.Run_n_raw = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge Clk);
      want = {i >= 6, i == 6};
      ncmp++;
      if ({io.Run, io.Run_pulse} !== want) begin
        nfail++;
        $display("FAIL press_lat edge=%0d got=%b want=%b",
                 i, {io.Run, io.Run_pulse}, want);
      end
      ncmp++;
      if (dut_vec() !== mod_vec()) begin
        nfail++;
        $display("FAIL press_model got=%h want=%h", dut_vec(), mod_vec());
      end
    end
    io.Run_n_raw = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge Clk);
      want = {i < 6, 1'b0};
      ncmp++;
      if ({io.Run, io.Run_pulse} !== want) begin
        nfail++;
        $display("FAIL release_lat edge=%0d got=%b want=%b",
                 i, {io.Run, io.Run_pulse}, want);
      end
    end
  endtask

  task automatic test_bounce_press();
    logic [4:0] pat;
    int np;
    pat = 5'b01010;
    np = 0;
    for (int i = 0; i < 20; i++) begin
      io.Run_n_raw = (i < 5) ? pat[4-i] : 1'b0;
      @(negedge Clk);
      np += int'(io.Run_pulse);
      ncmp++;
      if (dut_vec() !== mod_vec()) begin
        nfail++;
        $display("FAIL bounce_model cyc=%0d got=%h want=%h",
                 i, dut_vec(), mod_vec());
      end
    end
    ncmp++;
    if (np !== 1 || io.Run !== 1'b1) begin
      nfail++;
      $display("FAIL bounce_press pulses=%0d run=%b want 1/1", np, io.Run);
    end
  endtask

  task automatic test_release_bounce();
    int np;
    int drops;
    np = 0;
    drops = 0;
    for (int i = 0; i < 10; i++) begin
      io.Run_n_raw = (i < 2) ? 1'b1 : 1'b0;
      @(negedge Clk);
      np += int'(io.Run_pulse);
      drops += int'(!io.Run);
    end
    ncmp++;
    if (np !== 0 || drops !== 0) begin
      nfail++;
      $display("FAIL rel_bounce pulses=%0d low_cycles=%0d want 0/0",
               np, drops);
    end
    io.Run_n_raw = 1'b1;
    repeat (10) @(negedge Clk);
    ncmp++;
    if (io.Run !== 1'b0 || dut_vec() !== mod_vec()) begin
      nfail++;
      $display("FAIL clean_release run=%b vec=%h want 0 / %h",
               io.Run, dut_vec(), mod_vec());
    end
  endtask

  task automatic test_s_busy();
    io.Busy = 1'b0;
    io.S_raw = 8'h12;
    repeat (4) @(negedge Clk);
    ncmp++;
    if (io.S !== 8'h12) begin
      nfail++;
      $display("FAIL s_load got=%h want=12", io.S);
    end
    io.Busy = 1'b1;
    io.S_raw = 8'h7F;
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      ncmp++;
      if (io.S !== 8'h12) begin
        nfail++;
        $display("FAIL s_hold cyc=%0d got=%h want=12", i, io.S);
      end
    end
    io.Busy = 1'b0;
    @(negedge Clk);
    ncmp++;
    if (io.S !== 8'h7F) begin
      nfail++;
      $display("FAIL s_unfreeze got=%h want=7f", io.S);
    end
  endtask

  task automatic test_reset_mid_press();
    int np;
    int k;
    np = 0;
    io.Run_n_raw = 1'b0;
    repeat (4) @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    ncmp++;
    if ({io.Run, io.Run_pulse} !== 2'b00) begin
      nfail++;
      $display("FAIL midreset_outs got=%b want=00", {io.Run, io.Run_pulse});
    end
    Reset = 1'b0;
    k = 0;
    while (io.Run !== 1'b1 && k < 12) begin
      @(negedge Clk);
      np += int'(io.Run_pulse);
      k++;
      ncmp++;
      if (dut_vec() !== mod_vec()) begin
        nfail++;
        $display("FAIL midreset_model cyc=%0d got=%h want=%h",
                 k, dut_vec(), mod_vec());
      end
    end
    ncmp++;
    if (io.Run !== 1'b1 || np !== 1 || k < DEB + 2) begin
      nfail++;
      $display("FAIL midreset_accept run=%b pulses=%0d edges=%0d",
               io.Run, np, k);
    end
    io.Run_n_raw = 1'b1;
    repeat (10) @(negedge Clk);
  endtask

  task automatic test_back_to_back();
    io.Run_n_raw = 1'b0;
    io.ClearA_LoadB_n_raw = 1'b0;
    repeat (7) @(negedge Clk);
    ncmp++;
    if ({io.Run, io.ClearA_LoadB, io.Run_pulse, io.ClearA_LoadB_pulse}
        !== 4'b1111) begin
      nfail++;
      $display("FAIL simul_press got=%b want=1111",
               {io.Run, io.ClearA_LoadB, io.Run_pulse,
                io.ClearA_LoadB_pulse});
    end
    io.Run_n_raw = 1'b1;
    io.ClearA_LoadB_n_raw = 1'b1;
    repeat (10) @(negedge Clk);
  endtask

  task automatic test_random();
    int hold0;
    int hold1;
    hold0 = 0;
    hold1 = 0;
    for (int i = 0; i < 600; i++) begin
      if (hold0 == 0) begin
        io.Run_n_raw = $urandom_range(0, 1) == 1;
        hold0 = $urandom_range(1, 9);
      end
      if (hold1 == 0) begin
        io.ClearA_LoadB_n_raw = $urandom_range(0, 1) == 1;
        hold1 = $urandom_range(1, 9);
      end
      hold0--;
      hold1--;
      io.S_raw = SW'($urandom);
      io.Busy = $urandom_range(0, 3) == 0;
      Reset = $urandom_range(0, 99) == 0;
      @(negedge Clk);
      ncmp++;
      if (dut_vec() !== mod_vec()) begin
        nfail++;
        $display("FAIL random cyc=%0d got=%h want=%h",
                 i, dut_vec(), mod_vec());
      end
    end
    Reset = 1'b0;
  endtask

  initial begin
    ncmp = 0;
    nfail = 0;
    test_reset();
    test_press_latency();
    test_bounce_press();
    test_release_bounce();
    test_s_busy();
    test_reset_mid_press();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
